// File: rtl/iir_output_decimator.sv
// Boxcar-average decimator for the IIR cascade output: round, saturate and
// buffer averaged words in a first-word-fall-through FIFO with valid/ready.
module iir_output_decimator #(
    parameter int unsigned DECIM      = 4,
    parameter int unsigned LOG2_DECIM = 2,
    parameter int unsigned SHIFT      = 16,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   in_data,
    input  logic                          in_valid,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sat,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned IN_W = 32;
    localparam int unsigned AW   = IN_W + LOG2_DECIM + 1;
    localparam int unsigned T    = LOG2_DECIM + SHIFT;
    localparam int unsigned RW   = ((AW > T) ? AW : T) + 2;
    localparam int unsigned CW   = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = PW + 1;
    localparam logic [RW-1:0] HALF = RW'(1) << (T - 1);

    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q;
    logic                 sat_q, sat_d;
    logic                 ovf_q, ovf_d;
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         sample_ext;
    logic [AW-1:0]         sum;
    logic [RW-1:0]         biased;
    logic signed [RW-1:0]  rnd;
    logic [RW-OUT_WIDTH:0] hi_bits;
    logic                  fits;
    logic [OUT_WIDTH-1:0]  word;
    logic                  group_done;
    logic                  empty, full, pop, wr_en, drop;

    // Group sum, round-half-up shift and clamp to the output range
    always_comb begin
        sample_ext = {{(AW - IN_W){in_data[IN_W-1]}}, in_data};
        sum        = acc_q + sample_ext;
        group_done = in_valid && (cnt_q == CW'(DECIM - 1));
        biased     = {{(RW - AW){sum[AW-1]}}, sum} + HALF;
        rnd        = $signed(biased) >>> T;
        hi_bits    = rnd[RW-1:OUT_WIDTH-1];
        fits       = (&hi_bits) | ~(|hi_bits);
        word       = fits ? rnd[OUT_WIDTH-1:0]
                          : {rnd[RW-1], {(OUT_WIDTH - 1){~rnd[RW-1]}}};
    end

    // Accumulator and FIFO next-state
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        data_d   = data_q;
        empty    = (level_q == LW'(0));
        full     = (level_q == LW'(FIFO_DEPTH));
        pop      = !empty && out_ready;
        wr_en    = group_done && (!full || pop);
        drop     = group_done && full && !pop;
        sat_d    = group_done && !fits;
        ovf_d    = ovf_q | drop;

        if (in_valid) begin
            if (group_done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);

        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // Head word for next cycle; a word pushed into an otherwise empty FIFO is the head
        if (level_d != LW'(0)) begin
            data_d = (wr_en && level_d == LW'(1)) ? word : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= (level_d != LW'(0));
            sat_q    <= sat_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage has no reset; entries are only read after being written
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= word;
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign sat        = sat_q;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: doc/iir_output_decimator.md
# iir_output_decimator

Downstream stage of the three-section IIR low-pass cascade. Consumes the cascade's signed 32-bit output stream and applies boxcar-average decimation by DECIM. Rounds and saturates each average to OUT_WIDTH bits and buffers results in a small FIFO. Results are presented to the consumer over a valid/ready interface. Overflow and saturation are reported as status.

## Interface

Parameters:
- DECIM, 4: decimation factor; power of two, 2..64.
- LOG2_DECIM, 2: log2(DECIM); must match DECIM.
- SHIFT, 16: extra arithmetic right shift applied after averaging. The total shift T = LOG2_DECIM + SHIFT must be at least 1.
- OUT_WIDTH, 16: signed output word width, 8..32.
- FIFO_DEPTH, 4: FIFO entries; power of two, 2..16.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_data, input, 32: signed filter output sample.
- in_valid, input, 1: in_data is a new sample this cycle. There is no backpressure upstream.
- out_data, output, OUT_WIDTH: signed decimated word at the FIFO head.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts out_data this cycle.
- sat, output, 1: one-cycle pulse on a push whose value was clamped.
- overflow, output, 1: sticky; set when a result is dropped because the FIFO is full.
- fifo_level, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation

- **Reset values:** out_data=0, out_valid=0, sat=0, overflow=0, fifo_level=0. The accumulator, sample counter and FIFO pointers are all 0. Reset asserted mid-group discards the partial sum.
- **Accumulator:** signed, 32+LOG2_DECIM+1 bits.
  - Each cycle with in_valid=1: acc += sign-extended in_data, and cnt increments.
  - Cycles with in_valid=0 leave acc and cnt unchanged.
- **Group completion:** when in_valid=1 and cnt==DECIM-1:
  - sum = acc + in_data.
  - r = (sum + 2^(T-1)) >>> T. This is round-half-up, i.e. toward +inf on exact ties.
  - r is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. If clamping occurs, sat=1 for that cycle.
  - The result is pushed; acc is cleared to 0 and cnt to 0 in the same cycle.
- **FIFO:** circular buffer with first-word-fall-through. out_data always shows the head entry and holds its last value when empty.
  - Pop occurs when out_valid & out_ready.
  - Push while full with no simultaneous pop: the new word is dropped, overflow is set, and sat still pulses if clamped.
  - Push while full with a simultaneous pop: accepted, and fifo_level is unchanged.
  - Simultaneous push and pop when the FIFO is empty: pop is ignored (out_valid=0), push is accepted.
- **overflow** clears only on reset.

## Timing

- Latency: the last sample of a group is sampled at edge k. The result is written at edge k. out_valid=1 and out_data=result are visible after edge k when the FIFO was empty.
- out_valid, out_data and fifo_level are registered or derived only from registered state. There is no combinational path from out_ready or in_* to outputs.
- Throughput: one result per DECIM valid input samples. With out_ready held at 1 the FIFO never holds more than 1 entry.
- out_data must remain stable while out_valid=1 and out_ready=0.
- sat is asserted in the cycle after edge k, for exactly one cycle.

## Test plan

All scenarios use the default parameters unless stated.

1. **Reset:** drive reset=0 with random inputs for 5 cycles -> all outputs 0. Release reset, idle 3 cycles -> out_valid stays 0.
2. **Basic decimation:** out_ready=1, four samples 0x00010000 -> exactly one word 0x0001. out_valid is high for one cycle, right after the 4th sample edge, and fifo_level returns to 0.
3. **Rounding:**
   - 4 x 0x00008000 -> 0x0001 (a tie, rounded up).
   - 4 x 0xFFFF8000 -> 0x0000.
   - 4 x 0x00007FFF -> 0x0000.
4. **Saturation:**
   - 4 x 0x7FFFFFFF -> 0x7FFF with sat=1.
   - 4 x 0x80000000 -> 0x8000 with sat=0.
5. **Backpressure and overflow:**
   - out_ready=0, feed 20 samples with group values 1..5 -> fifo_level=4 and overflow=1; the 5th word is lost.
   - Then out_ready=1 -> words 1,2,3,4 are drained in 4 consecutive cycles, and overflow stays 1.
   - Full FIFO with push and pop in the same cycle -> no overflow, fifo_level unchanged.
6. **Reset mid-group / gaps:**
   - 2 samples of 0x00040000, then reset pulse, then 4 x 0x00010000 -> a single output 0x0001.
   - in_valid gaps inserted between samples -> the result is unchanged.
